// File: rtl/ap_pkg.sv
// Shared constants and the sequencer state encoding for the AP datapath.
package ap_pkg;

    localparam int CELL_BIT = 8;   // bits per map cell
    localparam int N_CELL   = 9;   // cells per 3x3 window
    localparam int N_CORE   = 8;   // AP cores
    localparam int BIAS_W   = 16;  // bias word width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ap_win_gen.sv
// Window/step nested counter for ap_seq.
// Step is the innermost loop. In pool mode the outer loops walk pooled
// cells in raster order and visit the 2x2 quad inside each cell; in raster
// mode they walk every (row, col) of the output map. 'last' flags the final
// beat of the pass so the sequencer can stop issuing.
module ap_win_gen
    import ap_pkg::*;
#(
    parameter int DIM_W  = 5,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic              pool,
    input  logic [STEP_W-1:0] steps,
    input  logic [DIM_W:0]    out_h,
    input  logic [DIM_W:0]    out_w,
    output logic [DIM_W-1:0]  row,
    output logic [DIM_W-1:0]  col,
    output logic [STEP_W-1:0] step,
    output logic              last
);

    localparam logic [DIM_W:0]    DIM_ONE  = (DIM_W+1)'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    // a_r/a_c count pooled cells in pool mode and plain rows/cols otherwise
    logic [DIM_W:0] a_r;
    logic [DIM_W:0] a_c;
    logic [DIM_W:0] lim_r;
    logic [DIM_W:0] lim_c;
    logic           dy;
    logic           dx;
    logic           step_end;
    logic           quad_end;
    logic           col_end;
    logic           row_end;

    // Outer-loop limits: pool mode drops an odd trailing row/column
    always_comb begin
        lim_r = out_h - DIM_ONE;
        lim_c = out_w - DIM_ONE;
        if (pool) begin
            lim_r = {1'b0, out_h[DIM_W:1]} - DIM_ONE;
            lim_c = {1'b0, out_w[DIM_W:1]} - DIM_ONE;
        end
    end

    assign step_end = (step == steps);
    assign quad_end = !pool || (dy && dx);
    assign col_end  = (a_c == lim_c);
    assign row_end  = (a_r == lim_r);
    assign last     = step_end && quad_end && col_end && row_end;

    // In pool mode the coordinate is 2*cell + quad offset
    assign row = pool ? {a_r[DIM_W-2:0], dy} : a_r[DIM_W-1:0];
    assign col = pool ? {a_c[DIM_W-2:0], dx} : a_c[DIM_W-1:0];

    // Nested counter: step, then quad (00,01,10,11), then col, then row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step <= '0;
            dy   <= 1'b0;
            dx   <= 1'b0;
            a_c  <= '0;
            a_r  <= '0;
        end else if (clear) begin
            step <= '0;
            dy   <= 1'b0;
            dx   <= 1'b0;
            a_c  <= '0;
            a_r  <= '0;
        end else if (advance) begin
            if (!step_end) begin
                step <= step + STEP_ONE;
            end else begin
                step <= '0;
                if (!quad_end) begin
                    dx <= ~dx;
                    dy <= dy | dx;
                end else begin
                    dx <= 1'b0;
                    dy <= 1'b0;
                    if (!col_end) begin
                        a_c <= a_c + DIM_ONE;
                    end else begin
                        a_c <= '0;
                        a_r <= row_end ? '0 : a_r + DIM_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ap_seq.sv
// AP layer-pass sequencer: issues (row, col, step) beats to the fetch unit,
// drives the AP control bits from the configuration latched at start, and
// counts AP results until the expected number has arrived.
// Optional build macro: AP_SEQ_PERF_EN adds perf_busy / perf_stall counters.
//
// Handshake: win_valid is high for the whole of ISSUE; a beat transfers on
// any rising edge where win_valid && win_ready, and win_* hold steady while
// win_valid is high and win_ready is low.
module ap_seq
    import ap_pkg::*;
#(
    parameter int DIM_W  = 5,
    parameter int STEP_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIM_W:0]       cfg_out_h,
    input  logic [DIM_W:0]       cfg_out_w,
    input  logic [STEP_W-1:0]    cfg_steps,
    input  logic                 cfg_pool,
    input  logic                 cfg_relu,
    input  logic [2:0]           cfg_bound,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic [DIM_W-1:0]     win_row,
    output logic [DIM_W-1:0]     win_col,
    output logic [STEP_W-1:0]    win_step,
    output logic                 win_first,
    output logic                 ap_en,
    output logic                 ap_en_relu,
    output logic                 ap_en_mp,
    output logic [2:0]           ap_bound_level,
    output logic [STEP_W-1:0]    ap_step,
    input  logic                 ap_out_en,
    output logic                 busy,
    output logic                 done,
    output logic [2*DIM_W+1:0]   out_cnt,
    output state_t               dbg_state
`ifdef AP_SEQ_PERF_EN
    ,
    output logic [15:0]          perf_busy,
    output logic [15:0]          perf_stall
`endif
);

    localparam int CNT_W = 2*DIM_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;

    logic [DIM_W:0]    h_q;
    logic [DIM_W:0]    w_q;
    logic [STEP_W-1:0] steps_q;
    logic              pool_q;
    logic              relu_q;
    logic [2:0]        bound_q;

    logic              start_go;
    logic              empty_cfg;
    logic              fire;
    logic              win_last;
    logic [DIM_W:0]    cells_h;
    logic [DIM_W:0]    cells_w;
    logic [CNT_W-1:0]  expected;
    logic [CNT_W-1:0]  cnt_nxt;

    assign start_go = (state == ST_IDLE) && start;

    // A pass with no output cells (either dimension 0, or a pooled
    // dimension below 2) has nothing to issue and completes at once.
    assign empty_cfg = (cfg_out_h == '0) || (cfg_out_w == '0) ||
                       (cfg_pool && ((cfg_out_h[DIM_W:1] == '0) ||
                                     (cfg_out_w[DIM_W:1] == '0)));

    assign cells_h  = pool_q ? {1'b0, h_q[DIM_W:1]} : h_q;
    assign cells_w  = pool_q ? {1'b0, w_q[DIM_W:1]} : w_q;
    assign expected = {{(DIM_W+1){1'b0}}, cells_h} * {{(DIM_W+1){1'b0}}, cells_w};
    assign cnt_nxt  = (busy && ap_out_en) ? out_cnt + CNT_ONE : out_cnt;

    ap_win_gen #(
        .DIM_W  (DIM_W),
        .STEP_W (STEP_W)
    ) u_win_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_go),
        .advance (fire),
        .pool    (pool_q),
        .steps   (steps_q),
        .out_h   (h_q),
        .out_w   (w_q),
        .row     (win_row),
        .col     (win_col),
        .step    (win_step),
        .last    (win_last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        win_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = empty_cfg ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                win_valid = 1'b1;
                busy      = 1'b1;
                fire      = win_ready;
                if (win_ready && win_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (cnt_nxt >= expected) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ap_en          = fire;
    assign win_first      = win_valid && (win_step == '0);
    assign ap_en_relu     = relu_q;
    assign ap_en_mp       = pool_q;
    assign ap_bound_level = bound_q;
    assign ap_step        = steps_q;
    assign dbg_state      = state;

    // Configuration is captured once per pass and held until the next start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            w_q     <= '0;
            steps_q <= '0;
            pool_q  <= 1'b0;
            relu_q  <= 1'b0;
            bound_q <= '0;
        end else if (start_go) begin
            h_q     <= cfg_out_h;
            w_q     <= cfg_out_w;
            steps_q <= cfg_steps;
            pool_q  <= cfg_pool;
            relu_q  <= cfg_relu;
            bound_q <= cfg_bound;
        end
    end

    // AP result counter: cleared at start, counts only while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_cnt <= '0;
        end else if (start_go) begin
            out_cnt <= '0;
        end else begin
            out_cnt <= cnt_nxt;
        end
    end

`ifdef AP_SEQ_PERF_EN
    // Saturating busy-cycle and issue-stall counters, cleared at start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (start_go) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && (perf_busy != 16'hFFFF)) begin
                perf_busy <= perf_busy + 16'd1;
            end
            if (win_valid && !win_ready && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ap_seq.sv
// Directed bench for ap_seq: a reference loop nest builds the expected beat
// sequence; a negedge monitor compares each issued window against it.
module tb_ap_seq;

    localparam int DW     = 5;
    localparam int SW     = 3;
    localparam int EW     = 1 + 2*DW + SW;
    localparam int BUDGET = 20000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              start     = 1'b0;
    logic [DW:0]       cfg_out_h = '0;
    logic [DW:0]       cfg_out_w = '0;
    logic [SW-1:0]     cfg_steps = '0;
    logic              cfg_pool  = 1'b0;
    logic              cfg_relu  = 1'b0;
    logic [2:0]        cfg_bound = '0;
    logic              win_ready = 1'b1;
    logic              ap_out_en = 1'b0;
    logic              win_valid;
    logic [DW-1:0]     win_row;
    logic [DW-1:0]     win_col;
    logic [SW-1:0]     win_step;
    logic              win_first;
    logic              ap_en;
    logic              ap_en_relu;
    logic              ap_en_mp;
    logic [2:0]        ap_bound_level;
    logic [SW-1:0]     ap_step;
    logic              busy;
    logic              done;
    logic [2*DW+1:0]   out_cnt;
    ap_pkg::state_t    dbg_state;
`ifdef AP_SEQ_PERF_EN
    logic [15:0]       perf_busy;
    logic [15:0]       perf_stall;
`endif

    ap_seq #(.DIM_W(DW), .STEP_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_out_h      (cfg_out_h),
        .cfg_out_w      (cfg_out_w),
        .cfg_steps      (cfg_steps),
        .cfg_pool       (cfg_pool),
        .cfg_relu       (cfg_relu),
        .cfg_bound      (cfg_bound),
        .win_valid      (win_valid),
        .win_ready      (win_ready),
        .win_row        (win_row),
        .win_col        (win_col),
        .win_step       (win_step),
        .win_first      (win_first),
        .ap_en          (ap_en),
        .ap_en_relu     (ap_en_relu),
        .ap_en_mp       (ap_en_mp),
        .ap_bound_level (ap_bound_level),
        .ap_step        (ap_step),
        .ap_out_en      (ap_out_en),
        .busy           (busy),
        .done           (done),
        .out_cnt        (out_cnt),
        .dbg_state      (dbg_state)
`ifdef AP_SEQ_PERF_EN
        ,
        .perf_busy      (perf_busy),
        .perf_stall     (perf_stall)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] first_log[3];
    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_want;
    int total     = 0;
    int bad       = 0;
    int beats     = 0;
    int pulses    = 0;
    int pending   = 0;
    int bpo       = 1;
    int stall_cnt = 0;
    int max_row   = 0;
    int max_col   = 0;
    int last_cyc  = 0;
    int tick      = 0;
    int rdy_mode  = 0;
    bit busy_seen = 0;
    bit mon_en    = 1;
    bit inj       = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference beat order, written as the plain loop nest of the pass
    task automatic build_exp(input int h, input int w, input int st, input int pl);
        exp_q.delete();
        if (pl != 0) begin
            for (int pr = 0; pr < h/2; pr++)
                for (int pc = 0; pc < w/2; pc++)
                    for (int q = 0; q < 4; q++)
                        for (int s = 0; s <= st; s++)
                            exp_q.push_back({1'b0, DW'(2*pr + q/2), DW'(2*pc + q%2), SW'(s)});
        end else begin
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    for (int s = 0; s <= st; s++)
                        exp_q.push_back({1'b0, DW'(r), DW'(c), SW'(s)});
        end
    endtask

    // ---------------- input driver (win_ready, ap_out_en) ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick++;
            win_ready = (rdy_mode == 0) ? 1'b1 : ((tick % 3) == 0);
            if (inj) begin
                ap_out_en = 1'b1;
                inj = 0;
            end else if (pending > 0) begin
                ap_out_en = 1'b1;
                pending--;
                pulses++;
            end else begin
                ap_out_en = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (busy === 1'b1) busy_seen = 1;
        if (mon_en && (win_valid === 1'b1)) begin
            mon_got  = {1'b0, win_row, win_col, win_step};
            mon_want = (exp_q.size() > 0) ? exp_q[0] : {EW{1'b1}};
            check_val("win_pos", mon_got, mon_want);
            check_val("win_first", win_first, mon_want[SW-1:0] == '0);
            if (win_ready) begin
                check_val("ap_en_fire", ap_en, 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (beats < 3) first_log[beats] = mon_got;
                if (int'(win_row) > max_row) max_row = int'(win_row);
                if (int'(win_col) > max_col) max_col = int'(win_col);
                beats++;
                if ((beats % bpo) == 0) pending++;
            end else begin
                check_val("ap_en_stall", ap_en, 0);
                stall_cnt++;
            end
        end
    end

    // ---------------- pass driver ----------------
    task automatic run_pass(input int h, input int w, input int st, input int pl,
                            input int rl, input int bd, input int rm,
                            input int exp_beats, input int exp_out);
        int cyc;
        build_exp(h, w, st, pl);
        bpo       = ((pl != 0) ? 4 : 1) * (st + 1);
        beats     = 0;
        pulses    = 0;
        pending   = 0;
        stall_cnt = 0;
        max_row   = 0;
        max_col   = 0;
        busy_seen = 0;
        rdy_mode  = rm;
        @(posedge clk);
        #1;
        cfg_out_h = (DW+1)'(h);
        cfg_out_w = (DW+1)'(w);
        cfg_steps = SW'(st);
        cfg_pool  = (pl != 0);
        cfg_relu  = (rl != 0);
        cfg_bound = 3'(bd);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        // scramble inputs: the pass must run on the captured settings
        cfg_out_h = (DW+1)'($urandom_range(0, 63));
        cfg_out_w = (DW+1)'($urandom_range(0, 63));
        cfg_steps = SW'($urandom_range(0, 7));
        cfg_pool  = 1'($urandom_range(0, 1));
        cfg_relu  = 1'($urandom_range(0, 1));
        cfg_bound = 3'($urandom_range(0, 7));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((done !== 1'b1) && (cyc < BUDGET));
        last_cyc = cyc;
        check_val("done_in_budget", done, 1);
        check_val("beats", beats, exp_beats);
        check_val("out_cnt_at_done", out_cnt, exp_out);
        check_val("pulses_at_done", pulses, exp_out);
        check_val("exp_q_left", exp_q.size(), 0);
        check_val("busy_seen", busy_seen, exp_beats > 0);
        check_val("ap_en_relu", ap_en_relu, rl);
        check_val("ap_en_mp", ap_en_mp, pl);
        check_val("ap_bound_level", ap_bound_level, bd);
        check_val("ap_step", ap_step, st);
`ifdef AP_SEQ_PERF_EN
        check_val("perf_stall", perf_stall, stall_cnt);
`endif
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
        // a result pulse in IDLE must not move the held count
        inj = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("out_cnt_hold_idle", out_cnt, exp_out);
    endtask

    task automatic reset_mid_pass();
        build_exp(8, 8, 1, 1);
        bpo      = 8;
        beats    = 0;
        pending  = 0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        cfg_out_h = 6'd8;
        cfg_out_w = 6'd8;
        cfg_steps = 3'd1;
        cfg_pool  = 1'b1;
        cfg_relu  = 1'b1;
        cfg_bound = 3'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("pre_reset_busy", busy, 1);
        check_val("pre_reset_cnt_nonzero", out_cnt != '0, 1);
        @(posedge clk);
        #1;
        mon_en = 0;
        reset  = 1'b1;
        @(negedge clk);
        check_val("rst_win_valid", win_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ap_en", ap_en, 0);
        check_val("rst_relu", ap_en_relu, 0);
        check_val("rst_mp", ap_en_mp, 0);
        check_val("rst_bound", ap_bound_level, 0);
        check_val("rst_ap_step", ap_step, 0);
        check_val("rst_out_cnt", out_cnt, 0);
        check_val("rst_state", dbg_state, ap_pkg::ST_IDLE);
        pending = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_win_valid", win_valid, 0);
        check_val("reset_out_cnt", out_cnt, 0);
        check_val("reset_ap_en", ap_en, 0);
        check_val("reset_state", dbg_state, ap_pkg::ST_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 24x24 pooled, 2 steps: 144 cells x 4 quads x 2 steps
        run_pass(24, 24, 1, 1, 1, 3, 0, 1152, 144);
        check_val("first_beat0", first_log[0], {1'b0, 5'd0, 5'd0, 3'd0});
        check_val("first_beat1", first_log[1], {1'b0, 5'd0, 5'd0, 3'd1});
        check_val("first_beat2", first_log[2], {1'b0, 5'd0, 5'd1, 3'd0});

        // 10x10 raster, single step
        run_pass(10, 10, 0, 0, 0, 0, 0, 100, 100);

        // ready high one cycle in three: sequence unchanged under stalls
        run_pass(6, 5, 2, 0, 1, 7, 1, 90, 30);

        // 5x5 pooled: odd trailing row/col dropped
        run_pass(5, 5, 0, 1, 0, 1, 0, 16, 4);
        check_val("pool5_max_row", max_row, 3);
        check_val("pool5_max_col", max_col, 3);

        // zero height: no beats, done one cycle after start
        run_pass(0, 7, 1, 0, 0, 0, 0, 0, 0);
        check_val("h0_done_latency", last_cyc, 1);

        // reset in the middle of ISSUE, then a fresh pass with new settings
        reset_mid_pass();
        run_pass(3, 4, 1, 0, 0, 2, 1, 24, 12);
        check_val("post_reset_first", first_log[0], {1'b0, 5'd0, 5'd0, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
